// File: rtl/axi_mm_pkg.sv
// Shared AXI4 memory-mapped constants and
// FSM state encoding for the burst master.
package axi_mm_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_1B     = 3'b000;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_AW   = S_AW,
    ST_W    = S_W,
    ST_B    = S_B,
    ST_AR   = S_AR,
    ST_R    = S_R,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/axi_burst_master_if.sv
// Command port, byte streams and AXI4 channels.
// master = burst master view, slave = everything around it.
interface axi_burst_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_len;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  rd_ready;
  logic                  done;
  logic                  err;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [3:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rresp;
  logic                  rready;
  logic                  rlast;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_data, wr_valid, rd_ready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rvalid, rresp, rlast,
    output cmd_ready, wr_ready,
    output rd_data, rd_valid, rd_last,
    output done, err,
    output awaddr, awvalid, awlen, awsize, awburst,
    output wdata, wvalid, wlast, bready,
    output araddr, arvalid, arlen, arsize, arburst,
    output rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_data, wr_valid, rd_ready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rvalid, rresp, rlast,
    input  cmd_ready, wr_ready,
    input  rd_data, rd_valid, rd_last,
    input  done, err,
    input  awaddr, awvalid, awlen, awsize, awburst,
    input  wdata, wvalid, wlast, bready,
    input  araddr, arvalid, arlen, arsize, arburst,
    input  rready
  );

endinterface

// File: rtl/axi_burst_master.sv
// One INCR byte burst per command (1..16 beats).
// Ports: clk, rstn (async low), bus (master modport).
module axi_burst_master
  import axi_mm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstn,
  axi_burst_master_if.master bus
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_len;
  logic [3:0]            r_cnt;
  logic                  r_err;
  logic                  r_cmd_ready;

  logic w_st_w;
  logic w_st_r;
  logic w_last;
  logic w_w_hs;
  logic w_r_hs;

  assign w_st_w = (r_state == ST_W);
  assign w_st_r = (r_state == ST_R);
  assign w_last = (r_cnt == r_len);
  assign w_w_hs = w_st_w & bus.wr_valid & bus.wready;
  assign w_r_hs = w_st_r & bus.rvalid & bus.rd_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_addr      <= bus.cmd_addr;
            r_len       <= bus.cmd_len;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_state     <= bus.cmd_write ? ST_AW
                                         : ST_AR;
          end
        end
        ST_AW: if (bus.awready) r_state <= ST_W;
        ST_W: begin
          if (w_w_hs) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_last) r_state <= ST_B;
          end
        end
        ST_B: begin
          if (bus.bvalid) begin
            r_err   <= r_err |
                       (bus.bresp != RESP_OKAY);
            r_state <= ST_DONE;
          end
        end
        ST_AR: if (bus.arready) r_state <= ST_R;
        ST_R: begin
          if (w_r_hs) begin
            r_cnt <= r_cnt + 4'd1;
            // rlast must coincide with the
            // counted last beat, else flag it
            r_err <= r_err | bus.rresp |
                     (bus.rlast != w_last);
            if (w_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.done      = (r_state == ST_DONE);
  assign bus.err       = r_err;

  assign bus.awaddr  = r_addr;
  assign bus.awlen   = r_len;
  assign bus.awvalid = (r_state == ST_AW);
  assign bus.awsize  = SIZE_1B;
  assign bus.awburst = BURST_INCR;

  assign bus.araddr  = r_addr;
  assign bus.arlen   = r_len;
  assign bus.arvalid = (r_state == ST_AR);
  assign bus.arsize  = SIZE_1B;
  assign bus.arburst = BURST_INCR;

  assign bus.wvalid   = w_st_w & bus.wr_valid;
  assign bus.wdata    = w_st_w ? bus.wr_data
                               : {DATA_WIDTH{1'b0}};
  assign bus.wlast    = w_st_w & w_last;
  assign bus.wr_ready = w_st_w & bus.wready;
  assign bus.bready   = (r_state == ST_B);

  assign bus.rready   = w_st_r & bus.rd_ready;
  assign bus.rd_valid = w_st_r & bus.rvalid;
  assign bus.rd_data  = w_st_r ? bus.rdata
                               : {DATA_WIDTH{1'b0}};
  assign bus.rd_last  = w_st_r & bus.rlast;

endmodule
